// File: rtl/mvau_wload_pkg.sv
// Shared types and elaboration helpers for the MVAU weight loader.
package mvau_wload_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} wload_state_t;

  // True when addr_bw bits can address every word of a depth-entry memory.
  function automatic bit addr_bw_ok(input int unsigned depth, input int unsigned addr_bw);
    return (64'(1) << addr_bw) >= 64'(depth);
  endfunction

endpackage

// File: rtl/mvau_weight_ram.sv
// Simple dual-port weight RAM: one write port, one registered read-first read port.
module mvau_weight_ram #(
  parameter int unsigned WIDTH   = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_BW = 4,
  parameter int unsigned IDX_BW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [IDX_BW-1:0]  waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [ADDR_BW-1:0] raddr,
  output logic [WIDTH-1:0]   rdata
);

  localparam int unsigned CMP_BW = ADDR_BW + 1;

  (* ram_style = "auto" *) logic [WIDTH-1:0] mem [DEPTH];

  logic raddr_ok;

  assign raddr_ok = {1'b0, raddr} < CMP_BW'(DEPTH);

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Nonblocking read of the old word gives read-first on same-address collisions.
  always_ff @(posedge clk) begin
    if (rst)           rdata <= '0;
    else if (raddr_ok) rdata <= mem[raddr[IDX_BW-1:0]];
    else               rdata <= '0;
  end

endmodule

// File: rtl/mvau_weight_loader.sv
// Reloads an MVAU weight memory from an AXI-Stream and serves the PE's synchronous read port.
module mvau_weight_loader
  import mvau_wload_pkg::*;
#(
  parameter int unsigned SIMD         = 2,
  parameter int unsigned TW           = 1,
  parameter int unsigned WMEM_DEPTH   = 4,
  parameter int unsigned WMEM_ADDR_BW = 4
) (
  input  logic                    aclk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic [SIMD*TW-1:0]      s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic                    load_busy,
  output logic                    load_done,
  output logic                    load_err,
  output logic                    wmem_ready,
  input  logic [WMEM_ADDR_BW-1:0] wmem_addr,
  output logic [SIMD*TW-1:0]      wmem_out
);

  localparam int unsigned WIDTH  = SIMD * TW;
  localparam int unsigned IDX_BW = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1;
  localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

  if (!addr_bw_ok(WMEM_DEPTH, WMEM_ADDR_BW)) begin : g_bad_addr_bw
    $error("WMEM_ADDR_BW is too narrow for WMEM_DEPTH");
  end

  wload_state_t            state;
  wload_state_t            state_nxt;
  logic [WMEM_ADDR_BW-1:0] wr_addr;
  logic                    wr_en;
  logic                    at_last;

  assign at_last = (wr_addr == LAST_ADDR);

  always_ff @(posedge aclk) begin
    if (rst) begin
      state      <= IDLE;
      wr_addr    <= '0;
      load_err   <= 1'b0;
      wmem_ready <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (load_start) begin
            wr_addr    <= '0;
            load_err   <= 1'b0;
            wmem_ready <= 1'b0;
          end
        end
        LOAD: begin
          // Depth alone ends the load; tlast is only cross-checked against it.
          if (wr_en) begin
            wr_addr <= at_last ? '0 : wr_addr + WMEM_ADDR_BW'(1);
            if (s_axis_tlast != at_last) load_err <= 1'b1;
          end
        end
        DONE:    wmem_ready <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b0;
    load_busy     = 1'b0;
    load_done     = 1'b0;
    wr_en         = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) state_nxt = LOAD;
      end
      LOAD: begin
        s_axis_tready = 1'b1;
        load_busy     = 1'b1;
        wr_en         = s_axis_tvalid;
        if (s_axis_tvalid && at_last) state_nxt = DONE;
      end
      DONE: begin
        load_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  mvau_weight_ram #(
    .WIDTH   (WIDTH),
    .DEPTH   (WMEM_DEPTH),
    .ADDR_BW (WMEM_ADDR_BW),
    .IDX_BW  (IDX_BW)
  ) u_ram (
    .clk   (aclk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_addr[IDX_BW-1:0]),
    .wdata (s_axis_tdata),
    .raddr (wmem_addr),
    .rdata (wmem_out)
  );

endmodule

// File: tb/tb_mvau_weight_loader.sv
// Directed bench for mvau_weight_loader: loads, bubbles, tlast errors, reset, collisions, range.
module tb_mvau_weight_loader;

  logic       aclk = 1'b0;
  logic       rst;
  logic       load_start;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tlast;
  logic       s_axis_tready;
  logic       load_busy;
  logic       load_done;
  logic       load_err;
  logic       wmem_ready;
  logic [1:0] wmem_addr;
  logic [7:0] wmem_out;

  logic       l3_start;
  logic [7:0] d3;
  logic       v3;
  logic       t3;
  logic       tready3;
  logic       busy3;
  logic       done3;
  logic       err3;
  logic       ready3;
  logic [1:0] a3;
  logic [7:0] out3;

  int checks   = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  mvau_weight_loader #(.SIMD(2), .TW(4), .WMEM_DEPTH(4), .WMEM_ADDR_BW(2)) u_dut (
    .aclk(aclk), .rst(rst), .load_start(load_start),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready), .load_busy(load_busy), .load_done(load_done),
    .load_err(load_err), .wmem_ready(wmem_ready), .wmem_addr(wmem_addr), .wmem_out(wmem_out)
  );

  mvau_weight_loader #(.SIMD(2), .TW(4), .WMEM_DEPTH(3), .WMEM_ADDR_BW(2)) u_dut3 (
    .aclk(aclk), .rst(rst), .load_start(l3_start),
    .s_axis_tdata(d3), .s_axis_tvalid(v3), .s_axis_tlast(t3),
    .s_axis_tready(tready3), .load_busy(busy3), .load_done(done3),
    .load_err(err3), .wmem_ready(ready3), .wmem_addr(a3), .wmem_out(out3)
  );

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = 8'hEE;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL reset_tready: got %b want 0", s_axis_tready); end
    checks++; if (load_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", load_busy); end
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", load_done); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", load_err); end
    checks++; if (wmem_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", wmem_ready); end
    checks++; if (wmem_out !== 8'h00) begin failures++; $display("FAIL reset_out: got %h want 00", wmem_out); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_load();
    logic [7:0] exp_w [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    start_load();
    checks++; if (load_busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b want 1", load_busy); end
    checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL basic_tready: got %b want 1", s_axis_tready); end
    for (int i = 0; i < 4; i++) send(exp_w[i], i == 3);
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL basic_done: got %b want 1", load_done); end
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL basic_done_tready: got %b want 0", s_axis_tready); end
    checks++; if (wmem_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_early: got %b want 0", wmem_ready); end
    tick();
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse: got %b want 0", load_done); end
    checks++; if (wmem_ready !== 1'b1) begin failures++; $display("FAIL basic_ready: got %b want 1", wmem_ready); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL basic_err: got %b want 0", load_err); end
    for (int i = 0; i < 4; i++) begin
      wmem_addr = 2'(i);
      tick();
      checks++; if (wmem_out !== exp_w[i]) begin failures++; $display("FAIL basic_read%0d: got %h want %h", i, wmem_out, exp_w[i]); end
    end
  endtask

  task automatic test_bubbles();
    logic [7:0] exp_w [4] = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    start_load();
    send(exp_w[0], 1'b0);
    tick();
    tick();
    checks++; if (load_busy !== 1'b1) begin failures++; $display("FAIL bubble_busy: got %b want 1", load_busy); end
    send(exp_w[1], 1'b0);
    tick();
    tick();
    send(exp_w[2], 1'b0);
    send(exp_w[3], 1'b1);
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL bubble_done: got %b want 1", load_done); end
    tick();
    for (int i = 0; i < 4; i++) begin
      wmem_addr = 2'(i);
      tick();
      checks++; if (wmem_out !== exp_w[i]) begin failures++; $display("FAIL bubble_read%0d: got %h want %h", i, wmem_out, exp_w[i]); end
    end
  endtask

  task automatic test_tlast_err();
    start_load();
    send(8'h10, 1'b0);
    send(8'h20, 1'b1);
    checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL early_last_err: got %b want 1", load_err); end
    checks++; if (load_busy !== 1'b1) begin failures++; $display("FAIL early_last_busy: got %b want 1", load_busy); end
    send(8'h30, 1'b0);
    send(8'h40, 1'b1);
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL early_last_done: got %b want 1", load_done); end
    tick();
    checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b want 1", load_err); end
    start_load();
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL err_clear: got %b want 0", load_err); end
    checks++; if (wmem_ready !== 1'b0) begin failures++; $display("FAIL ready_clear: got %b want 0", wmem_ready); end
    for (int i = 0; i < 4; i++) send(8'(8'h01 + i), 1'b0);
    checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL missing_last_err: got %b want 1", load_err); end
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL missing_last_done: got %b want 1", load_done); end
    tick();
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] exp_w [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    start_load();
    send(8'h99, 1'b0);
    send(8'h98, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL rstmid_tready: got %b want 0", s_axis_tready); end
    checks++; if (load_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", load_busy); end
    checks++; if (wmem_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready: got %b want 0", wmem_ready); end
    tick();
    start_load();
    for (int i = 0; i < 4; i++) send(exp_w[i], i == 3);
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL rstmid_done: got %b want 1", load_done); end
    tick();
    for (int i = 0; i < 4; i++) begin
      wmem_addr = 2'(i);
      tick();
      checks++; if (wmem_out !== exp_w[i]) begin failures++; $display("FAIL rstmid_read%0d: got %h want %h", i, wmem_out, exp_w[i]); end
    end
  endtask

  task automatic test_collision();
    start_load();
    send(8'hA1, 1'b0);
    send(8'hB2, 1'b0);
    send(8'hC3, 1'b0);
    send(8'hD4, 1'b1);
    tick();
    start_load();
    wmem_addr = 2'd0;
    send(8'h55, 1'b0);
    checks++; if (wmem_out !== 8'hA1) begin failures++; $display("FAIL collide_old: got %h want a1", wmem_out); end
    checks++; if (wmem_ready !== 1'b0) begin failures++; $display("FAIL collide_ready: got %b want 0", wmem_ready); end
    tick();
    checks++; if (wmem_out !== 8'h55) begin failures++; $display("FAIL collide_new: got %h want 55", wmem_out); end
    send(8'h66, 1'b0);
    send(8'h77, 1'b0);
    send(8'h88, 1'b1);
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL collide_done: got %b want 1", load_done); end
    tick();
    checks++; if (wmem_ready !== 1'b1) begin failures++; $display("FAIL collide_ready_end: got %b want 1", wmem_ready); end
  endtask

  task automatic test_ignored_start();
    logic [7:0] exp_w [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    start_load();
    send(exp_w[0], 1'b0);
    load_start = 1'b1;
    send(exp_w[1], 1'b0);
    load_start = 1'b0;
    send(exp_w[2], 1'b0);
    send(exp_w[3], 1'b1);
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL ignstart_done: got %b want 1", load_done); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL ignstart_err: got %b want 0", load_err); end
    tick();
    for (int i = 0; i < 4; i++) begin
      wmem_addr = 2'(i);
      tick();
      checks++; if (wmem_out !== exp_w[i]) begin failures++; $display("FAIL ignstart_read%0d: got %h want %h", i, wmem_out, exp_w[i]); end
    end
  endtask

  task automatic test_out_of_range();
    l3_start = 1'b1;
    tick();
    l3_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d3 = 8'(8'h31 + i);
      v3 = 1'b1;
      t3 = (i == 2);
      tick();
      v3 = 1'b0;
      t3 = 1'b0;
    end
    checks++; if (done3 !== 1'b1) begin failures++; $display("FAIL d3_done: got %b want 1", done3); end
    tick();
    checks++; if (ready3 !== 1'b1) begin failures++; $display("FAIL d3_ready: got %b want 1", ready3); end
    checks++; if (err3 !== 1'b0) begin failures++; $display("FAIL d3_err: got %b want 0", err3); end
    a3 = 2'd2;
    tick();
    checks++; if (out3 !== 8'h33) begin failures++; $display("FAIL d3_read2: got %h want 33", out3); end
    a3 = 2'd3;
    tick();
    checks++; if (out3 !== 8'h00) begin failures++; $display("FAIL d3_read_oor: got %h want 00", out3); end
    a3 = 2'd0;
    tick();
    checks++; if (out3 !== 8'h31) begin failures++; $display("FAIL d3_read0: got %h want 31", out3); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    load_start    = 1'b0;
    s_axis_tdata  = 8'hEE;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    wmem_addr     = 2'd0;
    l3_start      = 1'b0;
    d3            = 8'h00;
    v3            = 1'b0;
    t3            = 1'b0;
    a3            = 2'd0;
    test_reset();
    test_basic_load();
    test_bubbles();
    test_tlast_err();
    test_reset_mid_load();
    test_collision();
    test_ignored_start();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mvau_weight_loader.md
Name: mvau_weight_loader

Overview:
- Write-side counterpart of the MVAU weight memory.
- Accepts weight words over an AXI-Stream slave and writes them sequentially into an internal simple-dual-port weight RAM.
- Exposes the same synchronous read port the MVAU compute path already uses, so weights can be reloaded at runtime instead of fixed at synthesis.
- Sits between the host/DMA weight stream and one PE's weight read path.

Parameters:
SIMD, 2, input channels processed per PE; word width factor
TW, 1, weight bit width
WMEM_DEPTH, 4, words per memory, equal to (KDim^2*IFMCh*OFMCh)/(SIMD*PE)
WMEM_ADDR_BW, 4, address width; must be >= clog2(WMEM_DEPTH)

Ports:
aclk  in  1  main clock
rst  in  1  reset, synchronous, active-high
load_start  in  1  single-cycle request to begin a full reload
s_axis_tdata  in  SIMD*TW  weight word
s_axis_tvalid  in  1  stream valid
s_axis_tlast  in  1  marks final word of a load
s_axis_tready  out  1  stream ready
load_busy  out  1  high while in LOAD
load_done  out  1  one-cycle pulse when a load completes
load_err  out  1  sticky tlast mismatch flag
wmem_ready  out  1  memory holds a complete, valid weight set
wmem_addr  in  WMEM_ADDR_BW  read address
wmem_out  out  SIMD*TW  read data

Behaviour:
- Single clock domain. Reset is synchronous, active-high. All state updates on posedge aclk.
- Reset values:
  - state=IDLE, write counter wr_addr=0.
  - s_axis_tready=0, load_busy=0, load_done=0, load_err=0, wmem_ready=0, wmem_out=0.
  - RAM contents are not cleared.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - load_start=1 -> LOAD.
  - Same edge: wr_addr<=0, wmem_ready<=0, load_err<=0.
- LOAD:
  - s_axis_tready=1 combinationally; load_busy=1.
  - On tvalid&tready: write tdata to RAM[wr_addr], then wr_addr<=wr_addr+1.
  - If the accepted word is at wr_addr==WMEM_DEPTH-1: go to DONE and reset wr_addr to 0 (wrap).
  - No write occurs on cycles where tvalid=0.
- DONE (one cycle):
  - load_done=1, tready=0.
  - wmem_ready<=1 at the exit edge; next state IDLE.
- tlast check:
  - tlast=1 on a word with wr_addr!=WMEM_DEPTH-1 sets load_err.
  - tlast=0 on the word at WMEM_DEPTH-1 also sets load_err.
  - Word counting is by depth only; tlast never terminates a load early.
  - load_err is cleared only by rst or load_start.
- load_start is ignored while in LOAD or DONE.
- Reset mid-LOAD: returns to IDLE with wmem_ready=0. Partial RAM contents remain but are marked invalid.
- Read port:
  - Registered, 1-cycle latency: wmem_out <= RAM[wmem_addr]. Latency and timing match the existing weight memory.
  - Reads are always permitted, including during LOAD; consumers gate on wmem_ready.
  - Same-address read and write in one cycle is read-first: wmem_out returns the old word.
  - wmem_addr >= WMEM_DEPTH: wmem_out <= 0.
- Width: tdata and wmem_out are exactly SIMD*TW bits, with no sign or zero extension. wr_addr is WMEM_ADDR_BW bits.
- Throughput: one word per cycle when tvalid is held high. A full load occupies WMEM_DEPTH LOAD cycles plus 1 DONE cycle.

Decomposition:
- Package mvau_wload_pkg:
  - typedef enum logic [1:0] {IDLE, LOAD, DONE} wload_state_t
  - function for the address-width check (elaboration assertion that WMEM_ADDR_BW >= clog2(WMEM_DEPTH)).
- Sub-module mvau_weight_ram: simple dual port, 1 write and 1 registered read, read-first, with (* ram_style = "auto" *).
- The loader holds only the FSM, counter, flags and stream handshake.

Test Plan:
1. Basic load (SIMD=2, TW=4, DEPTH=4, ADDR_BW=2):
   - Stimulus: rst, load_start, then stream 0xA1,0xB2,0xC3,0xD4 with tlast on the 4th.
   - Response: load_done pulses one cycle after the 4th handshake; wmem_ready=1, load_err=0.
   - Reading addr 0..3 returns A1,B2,C3,D4 with 1-cycle latency.
2. Backpressure/bubbles: same data with tvalid toggled 1,0,0,1,... -> RAM contents are identical and no writes occur on tvalid=0 cycles.
3. tlast errors:
   - tlast on the 2nd word -> load_err=1 and the load still completes after 4 words.
   - Next load_start clears load_err.
   - tlast missing on the 4th word -> load_err=1.
4. Reset mid-load: after 2 words, assert rst -> state IDLE, tready=0, wmem_ready=0. A subsequent full load of 0x11..0x44 reads back correctly.
5. Read-first collision and reload:
   - After load 1, start load 2 writing 0x55 to addr 0 while reading addr 0 in the same cycle -> wmem_out=0xA1, then 0x55 on the next read.
   - wmem_ready is low during load 2.
6. Ignored start and out-of-range read:
   - load_start pulsed mid-LOAD -> no restart; wr_addr continues.
   - With DEPTH=3, ADDR_BW=2, read addr 3 -> wmem_out=0.
